// File: rtl/logic_op_pkg.sv
// rtl/logic_op_pkg.sv - opcode and FSM state definitions for the logic-op arbiter
package logic_op_pkg;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_NOT  = 3'd2;
    localparam logic [2:0] OP_XOR  = 3'd3;
    localparam logic [2:0] OP_NAND = 3'd4;
    localparam logic [2:0] OP_NOR  = 3'd5;
    localparam logic [2:0] OP_XNOR = 3'd6;
    localparam logic [2:0] OP_INV  = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/logic_unit.sv
// rtl/logic_unit.sv - combinational bitwise logic unit shared by all requesters
module logic_unit #(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic             err
);
    import logic_op_pkg::*;

    // Decode the opcode into a single bitwise result; unknown codes give zero and raise err
    always_comb begin
        y   = '0;
        err = 1'b0;
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_NOT:  y = ~a;
            OP_XOR:  y = a ^ b;
            OP_NAND: y = ~(a & b);
            OP_NOR:  y = ~(a | b);
            OP_XNOR: y = ~(a ^ b);
            default: begin
                y   = '0;
                err = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/logic_op_arbiter.sv
// rtl/logic_op_arbiter.sv - round-robin arbiter sharing one logic unit among NREQ requesters
module logic_op_arbiter #(
    parameter  int WIDTH = 8,
    parameter  int NREQ  = 4,
    localparam int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [3*NREQ-1:0]     op,
    input  logic [WIDTH*NREQ-1:0] a,
    input  logic [WIDTH*NREQ-1:0] b,
    output logic [NREQ-1:0]       gnt,
    output logic                  busy,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WIDTH-1:0]      rsp_data,
    output logic [IDW-1:0]        rsp_id,
    output logic                  rsp_err,
    output logic [15:0]           op_cnt
);
    import logic_op_pkg::*;

    state_t           state;
    state_t           next_state;
    logic [IDW-1:0]   last;
    logic [IDW-1:0]   winner;
    logic [2:0]       lat_op;
    logic [WIDTH-1:0] lat_a;
    logic [WIDTH-1:0] lat_b;

    logic             any_req;
    logic [IDW-1:0]   win_idx;
    logic [2:0]       sel_op;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [WIDTH-1:0] lu_y;
    logic             lu_err;

    assign busy = (state != IDLE);

    // Find the first requesting index after the last winner, wrapping around
    always_comb begin
        int             idx;
        logic [IDW-1:0] idx_w;
        any_req = 1'b0;
        win_idx = '0;
        idx     = 0;
        idx_w   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx   = (int'(last) + k) % NREQ;
            idx_w = IDW'(idx);
            if (!any_req && req[idx_w]) begin
                any_req = 1'b1;
                win_idx = idx_w;
            end
        end
    end

    // Select the winning requester's opcode and operands
    always_comb begin
        sel_op = '0;
        sel_a  = '0;
        sel_b  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_idx == IDW'(i)) begin
                sel_op = op[3*i +: 3];
                sel_a  = a[WIDTH*i +: WIDTH];
                sel_b  = b[WIDTH*i +: WIDTH];
            end
        end
    end

    logic_unit #(.WIDTH(WIDTH)) u_logic_unit (
        .op  (lat_op),
        .a   (lat_a),
        .b   (lat_b),
        .y   (lu_y),
        .err (lu_err)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state: grant, execute for one cycle, then hold the response until accepted
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (any_req) next_state = EXEC;
            EXEC:    next_state = RESP;
            RESP:    if (rsp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath: latch the winner's operands, capture the result, count completions
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last      <= IDW'(NREQ - 1);
            winner    <= '0;
            lat_op    <= '0;
            lat_a     <= '0;
            lat_b     <= '0;
            gnt       <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
            rsp_err   <= 1'b0;
            op_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        gnt    <= NREQ'(1) << win_idx;
                        winner <= win_idx;
                        lat_op <= sel_op;
                        lat_a  <= sel_a;
                        lat_b  <= sel_b;
                    end
                end
                EXEC: begin
                    gnt       <= '0;
                    rsp_data  <= lu_y;
                    rsp_err   <= lu_err;
                    rsp_id    <= winner;
                    rsp_valid <= 1'b1;
                    last      <= winner;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        op_cnt    <= op_cnt + 16'd1;
                    end
                end
                default: begin
                    gnt <= '0;
                end
            endcase
        end
    end

endmodule
